// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath width, the canonical NOP and the fetch FSM states.
package pipeline_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RESET,
        S_FETCH,
        S_HOLD,
        S_DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if #(
    parameter int unsigned XLEN = 32
) ();

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush beats load, otherwise the contents are held.
module if_id_register
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN = pipeline_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic [XLEN-1:0] pc_if_id,
    output logic [XLEN-1:0] instr_if_id,
    output logic            valid_if_id
);

    localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSTR);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic            valid_q;

    // A bubble always carries the NOP so downstream decode never sees stale bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (flush) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (load) begin
            pc_q    <= load_pc;
            instr_q <= load_instr;
            valid_q <= 1'b1;
        end
    end

    assign pc_if_id    = pc_q;
    assign instr_if_id = instr_q;
    assign valid_if_id = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, fetch FSM, one-entry stall buffer and branch redirect handling.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned    XLEN     = pipeline_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_pipeline,
    input  logic                 branch_taken_ex,
    input  logic [XLEN-1:0]      branch_target_ex,
    fetch_stage_if.master        imem,
    output logic [XLEN-1:0]      pc_if_id,
    output logic [XLEN-1:0]      instr_if_id,
    output logic                 valid_if_id
);

    localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSTR);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target_q, target_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [XLEN-1:0] buf_instr_q, buf_instr_d;

    logic            req;
    logic            ifid_load;
    logic            ifid_flush;
    logic [XLEN-1:0] ifid_pc;
    logic [XLEN-1:0] ifid_instr;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target_aligned;

    assign pc_plus4       = pc_q + XLEN'(4);
    assign target_aligned = {branch_target_ex[XLEN-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RESET;
            pc_q        <= RESET_PC;
            target_q    <= '0;
            buf_pc_q    <= '0;
            buf_instr_q <= NOP;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            target_q    <= target_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        target_d    = target_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        req         = 1'b0;
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        ifid_pc     = pc_q;
        ifid_instr  = imem.imem_rdata;

        unique case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                req = 1'b1;
                if (branch_taken_ex) begin
                    ifid_flush = 1'b1;
                    if (imem.imem_ready) begin
                        pc_d = target_aligned;
                    end else begin
                        // Request is in flight: wait it out at the old address.
                        target_d = target_aligned;
                        state_d  = S_DRAIN;
                    end
                end else if (imem.imem_ready) begin
                    pc_d = pc_plus4;
                    if (stall_pipeline) begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = imem.imem_rdata;
                        state_d     = S_HOLD;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end else if (!stall_pipeline) begin
                    ifid_flush = 1'b1;
                end
            end

            S_HOLD: begin
                if (branch_taken_ex) begin
                    ifid_flush = 1'b1;
                    pc_d       = target_aligned;
                    state_d    = S_FETCH;
                end else if (!stall_pipeline) begin
                    ifid_load  = 1'b1;
                    ifid_pc    = buf_pc_q;
                    ifid_instr = buf_instr_q;
                    state_d    = S_FETCH;
                end
            end

            S_DRAIN: begin
                req        = 1'b1;
                ifid_flush = 1'b1;
                if (branch_taken_ex) begin
                    target_d = target_aligned;
                end
                if (imem.imem_ready) begin
                    pc_d    = branch_taken_ex ? target_aligned : target_q;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;

    if_id_register #(
        .XLEN (XLEN)
    ) u_if_id_register (
        .clk         (clk),
        .rst         (rst),
        .load        (ifid_load),
        .flush       (ifid_flush),
        .load_pc     (ifid_pc),
        .load_instr  (ifid_instr),
        .pc_if_id    (pc_if_id),
        .instr_if_id (instr_if_id),
        .valid_if_id (valid_if_id)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns addr + 0x1000_0000 so every word is traceable.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] TAG = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_pipeline;
    logic        branch_taken_ex;
    logic [31:0] branch_target_ex;
    logic        ready;
    logic [31:0] pc_if_id;
    logic [31:0] instr_if_id;
    logic        valid_if_id;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage_if #(.XLEN(32)) bus ();

    assign bus.imem_ready = ready;
    assign bus.imem_rdata = bus.imem_addr + TAG;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_pipeline   (stall_pipeline),
        .branch_taken_ex  (branch_taken_ex),
        .branch_target_ex (branch_target_ex),
        .imem             (bus.master),
        .pc_if_id         (pc_if_id),
        .instr_if_id      (instr_if_id),
        .valid_if_id      (valid_if_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst              = 1'b1;
        stall_pipeline   = 1'b0;
        branch_taken_ex  = 1'b0;
        branch_target_ex = '0;
        ready            = 1'b1;
        tick();
        tick();
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(valid_if_id), 32'd0);
        chk("rst_pc", pc_if_id, 32'h0);
        chk("rst_instr", instr_if_id, NOP);

        // Streaming at zero wait states
        rst = 1'b0;
        tick();
        chk("s_req", 32'(bus.imem_req), 32'd1);
        chk("s_addr0", bus.imem_addr, 32'h0);
        chk("s_valid0", 32'(valid_if_id), 32'd0);
        tick();
        chk("s_addr4", bus.imem_addr, 32'h4);
        chk("s_valid1", 32'(valid_if_id), 32'd1);
        chk("s_pc0", pc_if_id, 32'h0);
        chk("s_instr0", instr_if_id, TAG);
        tick();
        chk("s_addr8", bus.imem_addr, 32'h8);
        chk("s_pc4", pc_if_id, 32'h4);

        // Two stall cycles while fetching 0x8
        stall_pipeline = 1'b1;
        tick();
        chk("st_req", 32'(bus.imem_req), 32'd0);
        chk("st_pc_hold", pc_if_id, 32'h4);
        chk("st_valid", 32'(valid_if_id), 32'd1);
        tick();
        chk("st_pc_hold2", pc_if_id, 32'h4);
        stall_pipeline = 1'b0;
        tick();
        chk("st_pc8", pc_if_id, 32'h8);
        chk("st_instr8", instr_if_id, TAG + 32'h8);
        chk("st_addrC", bus.imem_addr, 32'hC);
        chk("st_req1", 32'(bus.imem_req), 32'd1);
        tick();
        chk("st_pcC", pc_if_id, 32'hC);
        chk("st_addr10", bus.imem_addr, 32'h10);

        // Branch with response present
        branch_taken_ex  = 1'b1;
        branch_target_ex = 32'h100;
        tick();
        branch_taken_ex = 1'b0;
        chk("br_addr", bus.imem_addr, 32'h100);
        chk("br_valid", 32'(valid_if_id), 32'd0);
        chk("br_nop", instr_if_id, NOP);
        tick();
        chk("br_pc", pc_if_id, 32'h100);
        chk("br_valid1", 32'(valid_if_id), 32'd1);

        // Wait states at 0x10 with branch to 0x203 on first wait cycle
        branch_taken_ex  = 1'b1;
        branch_target_ex = 32'h10;
        tick();
        chk("dr_addr10", bus.imem_addr, 32'h10);
        ready            = 1'b0;
        branch_target_ex = 32'h203;
        tick();
        branch_taken_ex = 1'b0;
        chk("dr_req1", 32'(bus.imem_req), 32'd1);
        chk("dr_addr_w1", bus.imem_addr, 32'h10);
        chk("dr_valid", 32'(valid_if_id), 32'd0);
        tick();
        chk("dr_addr_w2", bus.imem_addr, 32'h10);
        tick();
        chk("dr_addr_w3", bus.imem_addr, 32'h10);
        chk("dr_req3", 32'(bus.imem_req), 32'd1);
        ready = 1'b1;
        tick();
        chk("dr_addr200", bus.imem_addr, 32'h200);
        chk("dr_drop", 32'(valid_if_id), 32'd0);
        tick();
        chk("dr_pc200", pc_if_id, 32'h200);
        chk("dr_addr204", bus.imem_addr, 32'h204);

        // Branch and stall together: branch wins
        branch_taken_ex  = 1'b1;
        stall_pipeline   = 1'b1;
        branch_target_ex = 32'h300;
        tick();
        branch_taken_ex = 1'b0;
        stall_pipeline  = 1'b0;
        chk("bs_valid", 32'(valid_if_id), 32'd0);
        chk("bs_addr", bus.imem_addr, 32'h300);
        tick();
        chk("bs_pc", pc_if_id, 32'h300);

        // Branch while parked in the stall buffer
        stall_pipeline = 1'b1;
        tick();
        chk("hb_req", 32'(bus.imem_req), 32'd0);
        branch_taken_ex  = 1'b1;
        branch_target_ex = 32'h400;
        tick();
        branch_taken_ex = 1'b0;
        stall_pipeline  = 1'b0;
        chk("hb_valid", 32'(valid_if_id), 32'd0);
        chk("hb_addr", bus.imem_addr, 32'h400);
        chk("hb_req1", 32'(bus.imem_req), 32'd1);
        tick();
        chk("hb_pc", pc_if_id, 32'h400);

        // Memory wait without stall produces a bubble
        ready = 1'b0;
        tick();
        chk("w_valid", 32'(valid_if_id), 32'd0);
        chk("w_addr", bus.imem_addr, 32'h404);
        ready = 1'b1;
        tick();
        chk("w_pc", pc_if_id, 32'h404);

        // PC wrap
        branch_taken_ex  = 1'b1;
        branch_target_ex = 32'hFFFF_FFFC;
        tick();
        branch_taken_ex = 1'b0;
        chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wr_next", bus.imem_addr, 32'h0);
        chk("wr_pc", pc_if_id, 32'hFFFF_FFFC);
        chk("wr_instr", instr_if_id, 32'h0FFF_FFFC);

        // Memory wait while stalled holds IF/ID
        ready          = 1'b0;
        stall_pipeline = 1'b1;
        tick();
        chk("ws_valid", 32'(valid_if_id), 32'd1);
        chk("ws_pc", pc_if_id, 32'hFFFF_FFFC);
        stall_pipeline = 1'b0;

        // Reset mid-request; ready during S_RESET is ignored
        rst = 1'b1;
        tick();
        chk("mr_req", 32'(bus.imem_req), 32'd0);
        chk("mr_pc", pc_if_id, 32'h0);
        chk("mr_instr", instr_if_id, NOP);
        rst   = 1'b0;
        ready = 1'b1;
        tick();
        chk("mr_addr", bus.imem_addr, 32'h0);
        chk("mr_valid", 32'(valid_if_id), 32'd0);
        chk("mr_req1", 32'(bus.imem_req), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter XLEN, default 32, address and instruction width.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall_pipeline  input  1  load-use stall from hazard_detection_unit; hold PC and IF/ID.
REQ-006 branch_taken_ex  input  1  redirect request from EX; flush younger fetches.
REQ-007 branch_target_ex  input  XLEN  redirect address.
REQ-008 imem_req  output  1  instruction-memory request valid.
REQ-009 imem_addr  output  XLEN  request address.
REQ-010 imem_ready  input  1  response valid for the outstanding request, same cycle as data.
REQ-011 imem_rdata  input  XLEN  instruction word.
REQ-012 pc_if_id  output  XLEN  IF/ID PC.
REQ-013 instr_if_id  output  XLEN  IF/ID instruction.
REQ-014 valid_if_id  output  1  IF/ID holds a real instruction; 0 = bubble.

Function
REQ-015 FSM states S_RESET, S_FETCH, S_HOLD, S_DRAIN shall be implemented.
REQ-016 S_RESET: imem_req=0; next cycle -> S_FETCH unconditionally.
REQ-017 S_FETCH: imem_req=1, imem_addr=pc; once asserted, imem_req and imem_addr shall stay stable until imem_ready.
REQ-018 S_FETCH, imem_ready=1, no branch, no stall: IF/ID <= {pc, imem_rdata, valid=1}; pc <= pc+4; stay S_FETCH (one instruction per cycle at zero-wait memory).
REQ-019 S_FETCH, imem_ready=1, stall_pipeline=1, no branch: response captured into one-entry buffer with its PC; pc <= pc+4; IF/ID held; -> S_HOLD.
REQ-020 S_FETCH, imem_ready=1, branch_taken_ex=1: response discarded; pc <= target; valid_if_id <= 0; stay S_FETCH.
REQ-021 S_FETCH, imem_ready=0, branch_taken_ex=1: target latched; valid_if_id <= 0; -> S_DRAIN.
REQ-022 S_FETCH, imem_ready=0, no branch: valid_if_id <= 0 unless stall_pipeline=1, in which case IF/ID is held.
REQ-023 S_HOLD: imem_req=0; stall_pipeline=0 -> IF/ID <= buffer with valid=1, -> S_FETCH; stall_pipeline=1 -> hold everything.
REQ-024 S_HOLD, branch_taken_ex=1: buffer dropped, pc <= target, valid_if_id <= 0, -> S_FETCH.
REQ-025 S_DRAIN: imem_req=1 at old address until imem_ready; response discarded; pc <= latched target; -> S_FETCH; a further branch_taken_ex in S_DRAIN replaces the latched target.
REQ-026 branch_taken_ex shall have priority over stall_pipeline in every state; flush forces valid_if_id=0.
REQ-027 Branch target bits [1:0] shall be forced to 2'b00.
REQ-028 pc+4 shall wrap modulo 2^XLEN without error.
REQ-029 When valid_if_id=0, instr_if_id shall read NOP 32'h0000_0013.

Reset
REQ-030 On rst=1 at a clock edge: state <= S_RESET, pc <= RESET_PC, buffer cleared, valid_if_id <= 0, pc_if_id <= 0, instr_if_id <= NOP, imem_req=0 the following cycle.
REQ-031 Reset mid-request shall abandon the outstanding fetch; an imem_ready arriving in S_RESET shall be ignored.

Structure
REQ-032 Shared package pipeline_pkg shall hold XLEN, NOP_INSTR, and the fetch_state_t enum.
REQ-033 IF/ID register (hold, flush, load) shall be the sub-module if_id_register; FSM and PC stay in fetch_stage.

Verification
REQ-034 Reset release, imem_ready tied 1 -> addresses 0x0,0x4,0x8 on consecutive cycles; IF/ID valid from cycle 2.
REQ-035 stall_pipeline=1 for 2 cycles while fetching 0x8 -> IF/ID holds 0x4 entry; 0x8 emitted first cycle after stall drops; no address skipped or duplicated.
REQ-036 branch_taken_ex=1, target 0x100, ready=1 -> next imem_addr 0x100; valid_if_id=0 one cycle.
REQ-037 Memory wait of 3 cycles at 0x10 with branch to 0x203 on first wait cycle -> req held at 0x10 until ready, response dropped, next fetch 0x200.
REQ-038 branch_taken_ex and stall_pipeline both 1 -> valid_if_id=0, fetch from target.
REQ-039 PC 0xFFFF_FFFC with ready=1 -> next imem_addr 0x0000_0000.
